// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control FSM state encoding, register-zero index and RV32 opcodes.
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_MEM_WAIT = 2'b01,
      ST_ERROR    = 2'b10
   } ctrl_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
   localparam logic [6:0] OPC_I_TYPE = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BEQ    = 7'b1100011;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose non-zero destination feeds either ID source.
module hazard_detect
   import cpu_pkg::*;
(
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic [4:0] ex_rd,
   input  logic       ex_mem_read,
   output logic       load_use
);

   logic [4:0] src [2];
   logic [1:0] src_match;

   assign src[0] = id_rs1;
   assign src[1] = id_rs2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         assign src_match[gi] = (src[gi] == ex_rd);
      end
   endgenerate

   // x0 is hardwired to zero, so a load targeting it can never create a dependency
   assign load_use = ex_mem_read && (ex_rd != REG_ZERO) && (|src_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: memory-wait FSM with timeout, load-use bubble and branch flush.
// Optional performance counters are enabled by defining PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl
   import cpu_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [4:0] ID_rs1_i,
   input  logic [4:0] ID_rs2_i,
   input  logic [4:0] EX_rd_i,
   input  logic       EX_MemRead_i,
   input  logic       ID_Branch_i,
   input  logic       ID_Taken_i,
   input  logic       MEM_req_i,
   input  logic       MEM_ack_i,
   output logic       PC_write_o,
   output logic       IFID_write_o,
   output logic       IDEX_bubble_o,
   output logic       IFID_flush_o,
   output logic       pipe_en_o,
   output logic       mem_err_o,
   output logic [1:0] state_o
`ifdef PIPELINE_CTRL_PERF_EN
   ,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
`endif
);

   localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

   ctrl_state_e state_reg, state_next;
   logic [7:0]  wait_cnt_reg, wait_cnt_next;
   logic        load_use;
   logic        mem_stall;

   logic pc_write, ifid_write, idex_bubble, ifid_flush, pipe_en, mem_err;

   hazard_detect u_hazard_detect (
      .id_rs1      (ID_rs1_i),
      .id_rs2      (ID_rs2_i),
      .ex_rd       (EX_rd_i),
      .ex_mem_read (EX_MemRead_i),
      .load_use    (load_use)
   );

   assign mem_stall = MEM_req_i && !MEM_ack_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg    <= ST_RUN;
         wait_cnt_reg <= 8'd0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   // The counter reaching the limit means MEM_TIMEOUT un-acked wait cycles have elapsed
   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      case (state_reg)
         ST_RUN: begin
            wait_cnt_next = 8'd0;
            if (mem_stall) state_next = ST_MEM_WAIT;
         end
         ST_MEM_WAIT: begin
            if (MEM_ack_i) begin
               state_next = ST_RUN;
            end else begin
               wait_cnt_next = wait_cnt_reg + 8'd1;
               if (wait_cnt_next == WAIT_LIMIT) state_next = ST_ERROR;
            end
         end
         ST_ERROR: state_next = ST_ERROR;
         default:  state_next = ST_RUN;
      endcase
   end

   // Priority in RUN: memory stall, then load-use bubble, then branch flush
   always_comb begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      pipe_en     = 1'b0;
      mem_err     = 1'b0;
      case (state_reg)
         ST_RUN: begin
            if (mem_stall) begin
               pipe_en = 1'b0;
            end else if (load_use) begin
               idex_bubble = 1'b1;
               pipe_en     = 1'b1;
            end else begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               pipe_en    = 1'b1;
               ifid_flush = ID_Branch_i && ID_Taken_i;
            end
         end
         ST_MEM_WAIT: begin
            if (MEM_ack_i) begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               pipe_en    = 1'b1;
            end
         end
         ST_ERROR: mem_err = 1'b1;
         default:  mem_err = 1'b0;
      endcase
   end

   // Outputs are forced low while reset is held, not only after the first edge
   assign PC_write_o    = pc_write    && rst_n_i;
   assign IFID_write_o  = ifid_write  && rst_n_i;
   assign IDEX_bubble_o = idex_bubble && rst_n_i;
   assign IFID_flush_o  = ifid_flush  && rst_n_i;
   assign pipe_en_o     = pipe_en     && rst_n_i;
   assign mem_err_o     = mem_err     && rst_n_i;
   assign state_o       = state_reg;

`ifdef PIPELINE_CTRL_PERF_EN
   logic [31:0] stall_cnt_reg, flush_cnt_reg;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stall_cnt_reg <= 32'd0;
         flush_cnt_reg <= 32'd0;
      end else begin
         if (!pc_write && (stall_cnt_reg != 32'hFFFF_FFFF))
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
         if (ifid_flush && (flush_cnt_reg != 32'hFFFF_FFFF))
            flush_cnt_reg <= flush_cnt_reg + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_reg;
   assign flush_cnt_o = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (MEM_TIMEOUT=4); output vector order is
// {PC_write, IFID_write, IDEX_bubble, IFID_flush, pipe_en, mem_err, state[1:0]}.
module tb_pipeline_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       ex_mem_read, id_branch, id_taken, mem_req, mem_ack;
   logic       pc_write, ifid_write, idex_bubble, ifid_flush, pipe_en, mem_err;
   logic [1:0] state;
`ifdef PIPELINE_CTRL_PERF_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   int tests  = 0;
   int failed = 0;

   localparam logic [7:0] V_RST   = 8'b0000_0000;
   localparam logic [7:0] V_IDLE  = 8'b1100_1000;
   localparam logic [7:0] V_LU    = 8'b0010_1000;
   localparam logic [7:0] V_FLUSH = 8'b1101_1000;
   localparam logic [7:0] V_MSTL  = 8'b0000_0000;
   localparam logic [7:0] V_WAIT  = 8'b0000_0001;
   localparam logic [7:0] V_ACK   = 8'b1100_1001;
   localparam logic [7:0] V_ERR   = 8'b0000_0110;

   pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .ID_rs1_i      (id_rs1),
      .ID_rs2_i      (id_rs2),
      .EX_rd_i       (ex_rd),
      .EX_MemRead_i  (ex_mem_read),
      .ID_Branch_i   (id_branch),
      .ID_Taken_i    (id_taken),
      .MEM_req_i     (mem_req),
      .MEM_ack_i     (mem_ack),
      .PC_write_o    (pc_write),
      .IFID_write_o  (ifid_write),
      .IDEX_bubble_o (idex_bubble),
      .IFID_flush_o  (ifid_flush),
      .pipe_en_o     (pipe_en),
      .mem_err_o     (mem_err),
      .state_o       (state)
`ifdef PIPELINE_CTRL_PERF_EN
      ,
      .stall_cnt_o   (stall_cnt),
      .flush_cnt_o   (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] outs();
      return {pc_write, ifid_write, idex_bubble, ifid_flush, pipe_en, mem_err, state};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("[TB] check %-14s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2, input logic br, input logic tk,
                         input logic rq, input logic ak);
      ex_mem_read = mr; ex_rd = rd; id_rs1 = r1; id_rs2 = r2;
      id_branch = br; id_taken = tk; mem_req = rq; mem_ack = ak;
   endtask

   // Apply inputs at a falling edge, check the combinational outputs, then cross one rising edge
   task automatic step(input string tag, input logic [7:0] exp);
      #1;
      chk(tag, {24'd0, outs()}, {24'd0, exp});
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      set_in(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      #2;
      chk("reset_outs", {24'd0, outs()}, {24'd0, V_RST});
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      set_in(0, 0, 0, 0, 0, 0, 0, 0);                 step("idle", V_IDLE);
      set_in(1, 5'd5, 5'd1, 5'd5, 0, 0, 0, 0);        step("lu_rs2", V_LU);
      set_in(0, 0, 0, 0, 0, 0, 0, 0);                 step("lu_one_cycle", V_IDLE);
      set_in(1, 5'd7, 5'd7, 5'd2, 0, 0, 0, 0);        step("lu_rs1", V_LU);
      set_in(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);        step("lu_rd_zero", V_IDLE);
      set_in(0, 5'd5, 5'd5, 5'd5, 0, 0, 0, 0);        step("no_memread", V_IDLE);
      set_in(0, 0, 0, 0, 1, 1, 0, 0);                 step("br_flush", V_FLUSH);
      set_in(0, 0, 0, 0, 1, 0, 0, 0);                 step("br_not_taken", V_IDLE);
      set_in(1, 5'd9, 5'd9, 5'd3, 1, 1, 0, 0);        step("br_vs_lu", V_LU);
      set_in(0, 0, 0, 0, 0, 0, 1, 1);                 step("req_ack_same", V_IDLE);

      // memory wait acknowledged three cycles after the request
      set_in(1, 5'd9, 5'd9, 5'd3, 1, 1, 1, 0);        step("mem_over_all", V_MSTL);
      set_in(0, 0, 0, 0, 0, 0, 1, 0);                 step("mem_wait1", V_WAIT);
                                                      step("mem_wait2", V_WAIT);
      set_in(0, 0, 0, 0, 0, 0, 1, 1);                 step("mem_ack", V_ACK);
      set_in(0, 0, 0, 0, 0, 0, 0, 0);                 step("mem_back_run", V_IDLE);

      // ack on the last allowed wait cycle beats the timeout
      set_in(0, 0, 0, 0, 0, 0, 1, 0);                 step("to_ack_req", V_MSTL);
      for (int i = 0; i < 3; i++)                     step("to_ack_wait", V_WAIT);
      set_in(0, 0, 0, 0, 0, 0, 1, 1);                 step("to_ack_wins", V_ACK);
      set_in(0, 0, 0, 0, 0, 0, 0, 0);                 step("to_ack_run", V_IDLE);

      // no ack: ERROR after four wait cycles, inputs ignored
      set_in(0, 0, 0, 0, 0, 0, 1, 0);                 step("to_req", V_MSTL);
      for (int i = 0; i < 4; i++)                     step("to_wait", V_WAIT);
                                                      step("to_error", V_ERR);
      set_in(1, 5'd4, 5'd4, 5'd4, 1, 1, 0, 1);        step("err_sticky1", V_ERR);
      set_in(0, 0, 0, 0, 0, 0, 0, 0);                 step("err_sticky2", V_ERR);
      #3 rst_n = 1'b0;
      #1 chk("err_reset", {24'd0, outs()}, {24'd0, V_RST});
      @(negedge clk);
      rst_n = 1'b1;
      step("err_rel_run", V_IDLE);

      // reset pulsed in the middle of a memory wait
      set_in(0, 0, 0, 0, 0, 0, 1, 0);                 step("mw_rst_req", V_MSTL);
                                                      step("mw_rst_wait", V_WAIT);
      #3 rst_n = 1'b0;
      #1 chk("mw_rst_async", {24'd0, outs()}, {24'd0, V_RST});
      @(negedge clk);
      rst_n = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);                 step("mw_rel_run", V_IDLE);
                                                      step("mw_no_residual", V_IDLE);

`ifdef PIPELINE_CTRL_PERF_EN
      rst_n = 1'b0;
      #1 chk("perf_rst_stall", stall_cnt, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      set_in(1, 5'd5, 5'd1, 5'd5, 0, 0, 0, 0);        step("perf_lu1", V_LU);
      set_in(0, 0, 0, 0, 0, 0, 0, 0);                 step("perf_idle", V_IDLE);
      set_in(1, 5'd5, 5'd1, 5'd5, 0, 0, 0, 0);        step("perf_lu2", V_LU);
      set_in(0, 0, 0, 0, 0, 0, 1, 0);                 step("perf_req", V_MSTL);
                                                      step("perf_wait1", V_WAIT);
                                                      step("perf_wait2", V_WAIT);
      set_in(0, 0, 0, 0, 0, 0, 1, 1);                 step("perf_ack", V_ACK);
      set_in(0, 0, 0, 0, 1, 1, 0, 0);                 step("perf_flush", V_FLUSH);
      #1;
      chk("stall_cnt", stall_cnt, 32'd5);
      chk("flush_cnt", flush_cnt, 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, the maximum number of MEM_WAIT cycles before an error.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports ID_rs1_i and ID_rs2_i, input, 5 bits each: source registers of the instruction in ID.
REQ-005 SHALL have port EX_rd_i, input, 5 bits, and port EX_MemRead_i, input, 1 bit: destination and load flag of the instruction in EX.
REQ-006 SHALL have port ID_Branch_i, input, 1 bit, and port ID_Taken_i, input, 1 bit: branch in ID, and its condition resolved true.
REQ-007 SHALL have port MEM_req_i, input, 1 bit: MEM stage holds a load or store; and port MEM_ack_i, input, 1 bit: data memory has completed it.
REQ-008 SHALL have port PC_write_o, output, 1 bit, and port IFID_write_o, output, 1 bit: PC and IF/ID update enables.
REQ-009 SHALL have port IDEX_bubble_o, output, 1 bit: zero the ID/EX control fields; and port IFID_flush_o, output, 1 bit: replace IF/ID with a NoOp.
REQ-010 SHALL have port pipe_en_o, output, 1 bit: update enable for ID/EX, EX/MEM and MEM/WB.
REQ-011 SHALL have port mem_err_o, output, 1 bit: memory timeout, sticky; and port state_o, output, 2 bits: current FSM state.

Function
REQ-012 SHALL implement a registered FSM with states RUN=2'b00, MEM_WAIT=2'b01, ERROR=2'b10; all outputs are combinational from the state and inputs.
REQ-013 SHALL detect load-use as EX_MemRead_i=1, EX_rd_i!=0, and EX_rd_i equal to ID_rs1_i or ID_rs2_i.
REQ-014 SHALL, in RUN with MEM_req_i=1 and MEM_ack_i=0, drive PC_write_o=0, IFID_write_o=0, pipe_en_o=0 in that cycle and enter MEM_WAIT next.
REQ-015 SHALL, in RUN with MEM_req_i=1 and MEM_ack_i=1 in the same cycle, not stall.
REQ-016 SHALL, in RUN with no memory stall and a load-use hazard, drive PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1, pipe_en_o=1 for exactly that cycle.
REQ-017 SHALL, in RUN with no memory stall, no load-use hazard, and ID_Branch_i=ID_Taken_i=1, drive IFID_flush_o=1 for one cycle, with PC_write_o=1.
REQ-018 SHALL give priority memory stall > load-use > branch flush; a lower-priority action is fully suppressed in that cycle.
REQ-019 SHALL, in MEM_WAIT, hold PC_write_o=IFID_write_o=pipe_en_o=0 and IDEX_bubble_o=IFID_flush_o=0 until MEM_ack_i=1.
REQ-020 SHALL, in the cycle MEM_ack_i=1 arrives in MEM_WAIT, drive pipe_en_o=1, PC_write_o=1, IFID_write_o=1 and return to RUN; hazards are re-evaluated from the next cycle.
REQ-021 SHALL keep an 8-bit wait counter: cleared on entry to MEM_WAIT, incremented each MEM_WAIT cycle without ack.
REQ-022 SHALL enter ERROR when the counter equals MEM_TIMEOUT without an ack; an ack in that same cycle wins and returns the FSM to RUN.
REQ-023 SHALL, in ERROR, freeze all enables, assert mem_err_o=1, and ignore all inputs until reset.
REQ-024 SHALL drive all outputs except IDEX_bubble_o, IFID_flush_o, mem_err_o and state_o high when in RUN with no hazard.

Reset
REQ-025 SHALL, while rst_n_i=0, asynchronously force state RUN, wait counter 0, and mem_err_o=0.
REQ-026 SHALL, during reset, drive PC_write_o=0, IFID_write_o=0, pipe_en_o=0, IDEX_bubble_o=0, IFID_flush_o=0, state_o=2'b00.
REQ-027 SHALL abandon any MEM_WAIT in progress on reset, with no residual stall after release.

Configuration
REQ-028 SHALL, with PIPELINE_CTRL_PERF_EN defined, add outputs stall_cnt_o (32 bits, cycles with PC_write_o=0) and flush_cnt_o (32 bits, cycles with IFID_flush_o=1).
REQ-029 SHALL make both counters saturate at 32'hFFFFFFFF and reset asynchronously to 0.
REQ-030 SHALL, without PIPELINE_CTRL_PERF_EN, omit both ports and the counter logic entirely.

Structure
REQ-031 SHALL take the state encoding, the REG_ZERO constant, and the RV32 opcode constants (R 0110011, I 0010011, load 0000011, store 0100011, beq 1100011) from shared package cpu_pkg.
REQ-032 SHALL place the load-use comparison in sub-module hazard_detect (purely combinational); the FSM, counters and priority logic are in pipeline_ctrl.

Verification
REQ-033 SHALL cover: EX_MemRead_i=1, EX_rd_i=5, ID_rs2_i=5 -> one cycle with PC_write_o=0, IDEX_bubble_o=1; EX_rd_i=0 -> no stall.
REQ-034 SHALL cover: ID_Branch_i=ID_Taken_i=1 with no hazard -> IFID_flush_o=1 for one cycle; the same cycle with a load-use hazard -> IFID_flush_o=0.
REQ-035 SHALL cover: MEM_req_i=1 with ack 3 cycles later -> pipe_en_o=0 for 3 cycles, state_o=01, then RUN.
REQ-036 SHALL cover: MEM_TIMEOUT=4 with no ack -> state_o=10 and mem_err_o=1 after 4 MEM_WAIT cycles, held until rst_n_i=0.
REQ-037 SHALL cover: rst_n_i pulsed low mid-MEM_WAIT -> outputs at reset values immediately, RUN after release.
REQ-038 SHALL cover, with PIPELINE_CTRL_PERF_EN defined: 2 load-use stalls plus a 3-cycle memory wait -> stall_cnt_o=5.
